// File: rtl/m_fetch_pkg.sv
// Shared CPU definitions for the fetch stage and its neighbours (XLEN, reset PC, imem width)
// plus small helpers for PC alignment and slot accounting.
package m_fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;
  localparam int IMEM_AW_DEF = 6;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_pkt_t;

  function automatic logic [XLEN-1:0] pc_align(input logic [XLEN-1:0] pc);
    return pc & ~32'd3;
  endfunction

  function automatic logic [1:0] slot_count(input logic a, input logic b, input logic c);
    return {1'b0, a} + {1'b0, b} + {1'b0, c};
  endfunction

endpackage

// File: rtl/m_fetch_skid.sv
// Output register backed by a one-entry skid buffer; flush drops both entries.
// Generic payload width so later pipeline stages can reuse it.
module m_fetch_skid #(
  parameter int DW = 64
) (
  input  logic          w_clk,
  input  logic          w_rst,
  input  logic          w_flush,
  input  logic          w_in_valid,
  input  logic [DW-1:0] w_in_data,
  input  logic          w_out_ready,
  output logic          w_out_valid,
  output logic [DW-1:0] w_out_data,
  output logic          w_skid_valid,
  output logic          w_pop
);

  logic          out_v_r;
  logic [DW-1:0] out_data_r;
  logic          skid_v_r;
  logic [DW-1:0] skid_data_r;
  logic          pop_s;

  assign pop_s        = out_v_r & w_out_ready;
  assign w_pop        = pop_s;
  assign w_out_valid  = out_v_r;
  assign w_out_data   = out_data_r;
  assign w_skid_valid = skid_v_r;

  // Output/skid update: skid drains first, an arriving entry refills whichever slot is free
  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      out_v_r     <= 1'b0;
      out_data_r  <= {DW{1'b0}};
      skid_v_r    <= 1'b0;
      skid_data_r <= {DW{1'b0}};
    end else if (w_flush) begin
      out_v_r  <= 1'b0;
      skid_v_r <= 1'b0;
    end else if (skid_v_r) begin
      if (pop_s) begin
        out_data_r <= skid_data_r;
        skid_v_r   <= w_in_valid;
        if (w_in_valid) begin
          skid_data_r <= w_in_data;
        end
      end
    end else if (w_in_valid) begin
      if (!out_v_r || pop_s) begin
        out_v_r    <= 1'b1;
        out_data_r <= w_in_data;
      end else begin
        skid_v_r    <= 1'b1;
        skid_data_r <= w_in_data;
      end
    end else if (pop_s) begin
      out_v_r <= 1'b0;
    end
  end

endmodule

// File: rtl/m_fetch.sv
// Instruction fetch: owns the PC, issues imem reads when downstream space is guaranteed,
// and restarts on a redirect pulse by flushing every fetched or in-flight instruction.
module m_fetch
  import m_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          IMEM_AW  = IMEM_AW_DEF
) (
  input  logic               w_clk,
  input  logic               w_rst,
  input  logic               w_redirect,
  input  logic [31:0]        w_redirect_pc,
  output logic [IMEM_AW-1:0] w_imem_addr,
  input  logic [31:0]        w_imem_data,
  output logic               w_out_valid,
  input  logic               w_out_ready,
  output logic [31:0]        w_out_pc,
  output logic [31:0]        w_out_inst
);

  logic [31:0] pc_r;
  logic        req_v_r;
  logic [31:0] req_pc_r;

  logic        pop_s;
  logic        out_v_s;
  logic        skid_v_s;
  logic [1:0]  busy_s;
  logic        issue_s;
  fetch_pkt_t  ret_pkt_s;
  fetch_pkt_t  out_pkt_s;

  assign w_imem_addr = pc_r[IMEM_AW+1:2];
  assign ret_pkt_s   = '{pc: req_pc_r, inst: w_imem_data};
  assign w_out_valid = out_v_s;
  assign w_out_pc    = out_pkt_s.pc;
  assign w_out_inst  = out_pkt_s.inst;

  // Issue only when the returning word is sure to find a free slot two cycles out
  always_comb begin
    busy_s  = slot_count(out_v_s & ~pop_s, skid_v_s, req_v_r);
    issue_s = 1'b0;
    if (!w_redirect && (busy_s < 2'd2)) begin
      issue_s = 1'b1;
    end else begin
      issue_s = 1'b0;
    end
  end

  // PC and in-flight request tracking; redirect overrides any issue
  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      pc_r     <= RESET_PC;
      req_v_r  <= 1'b0;
      req_pc_r <= 32'd0;
    end else if (w_redirect) begin
      pc_r    <= pc_align(w_redirect_pc);
      req_v_r <= 1'b0;
    end else if (issue_s) begin
      pc_r     <= pc_r + PC_STEP;
      req_v_r  <= 1'b1;
      req_pc_r <= pc_r;
    end else begin
      req_v_r <= 1'b0;
    end
  end

  m_fetch_skid #(.DW($bits(fetch_pkt_t))) u_skid (
    .w_clk        (w_clk),
    .w_rst        (w_rst),
    .w_flush      (w_redirect),
    .w_in_valid   (req_v_r),
    .w_in_data    (ret_pkt_s),
    .w_out_ready  (w_out_ready),
    .w_out_valid  (out_v_s),
    .w_out_data   (out_pkt_s),
    .w_skid_valid (skid_v_s),
    .w_pop        (pop_s)
  );

endmodule

// File: tb/tb_m_fetch.sv
// Bench for m_fetch: directed handshake/redirect/reset steps plus a random phase,
// checked against an in-order PC stream model with a random imem image.
module tb_m_fetch;

  localparam int AW = 6;

  logic          clk;
  logic          rst;
  logic          redirect;
  logic [31:0]   rpc;
  logic          ready;
  logic [AW-1:0] imem_addr, imem_addr2;
  logic [31:0]   imem_data, imem_data2;
  logic          out_valid, out_valid2;
  logic [31:0]   out_pc, out_pc2, out_inst, out_inst2;

  logic [31:0] mem [64];

  int total = 0;
  int bad   = 0;
  int k     = 0;
  int c_rst = 0;
  int pops  = 0;
  logic [31:0] exp_pc = 32'd0;
  logic [31:0] exp2_pc;
  logic [5:0]  exp6;
  logic        have_prev = 1'b0;
  logic        prev_v, prev_rdy;
  logic [31:0] prev_pc, prev_inst;

  m_fetch #(.RESET_PC(32'h0), .IMEM_AW(AW)) u_dut (
    .w_clk(clk), .w_rst(rst), .w_redirect(redirect), .w_redirect_pc(rpc),
    .w_imem_addr(imem_addr), .w_imem_data(imem_data),
    .w_out_valid(out_valid), .w_out_ready(ready),
    .w_out_pc(out_pc), .w_out_inst(out_inst)
  );

  m_fetch #(.RESET_PC(32'hF8), .IMEM_AW(AW)) u_dut2 (
    .w_clk(clk), .w_rst(rst), .w_redirect(1'b0), .w_redirect_pc(32'd0),
    .w_imem_addr(imem_addr2), .w_imem_data(imem_data2),
    .w_out_valid(out_valid2), .w_out_ready(1'b1),
    .w_out_pc(out_pc2), .w_out_inst(out_inst2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // synchronous-read instruction memories
  always @(posedge clk) begin
    imem_data  <= mem[imem_addr];
    imem_data2 <= mem[imem_addr2];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model, evaluated mid-cycle with this cycle's inputs.
  task automatic model_check();
    if (rst) begin
      k = 0; c_rst = 0; exp_pc = 32'h0; have_prev = 1'b0;
    end else begin
      if (k < 2) chk("restart_quiet", 32'(out_valid), 32'd0);
      else if (k == 2) chk("restart_valid", 32'(out_valid), 32'd1);
      if (have_prev && prev_v && !prev_rdy) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_pc", out_pc, prev_pc);
        chk("hold_inst", out_inst, prev_inst);
      end
      if (c_rst < 4) begin
        exp6 = 6'd62 + 6'(c_rst);
        chk("wrap_addr", 32'(imem_addr2), 32'(exp6));
      end
      if (c_rst >= 2 && c_rst < 5) begin
        exp2_pc = 32'hF8 + 32'(4 * (c_rst - 2));
        chk("wrap_valid", 32'(out_valid2), 32'd1);
        chk("wrap_pc", out_pc2, exp2_pc);
        chk("wrap_inst", out_inst2, mem[exp2_pc[AW+1:2]]);
      end
      if (out_valid && ready) begin
        chk("pop_pc", out_pc, exp_pc);
        chk("pop_inst", out_inst, mem[exp_pc[AW+1:2]]);
        exp_pc = exp_pc + 32'd4;
        pops++;
      end
      have_prev = !redirect;
      prev_v    = out_valid;
      prev_rdy  = ready;
      prev_pc   = out_pc;
      prev_inst = out_inst;
      if (redirect) begin
        exp_pc = {rpc[31:2], 2'b00};
        k = 0;
      end else if (k < 3) begin
        k++;
      end
      if (c_rst < 5) c_rst++;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_check();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; ready = 1'b1; redirect = 1'b0; rpc = 32'd0;
    for (int i = 0; i < 64; i++) mem[i] = $urandom;

    tick(); tick();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_pc", out_pc, 32'd0);
    chk("rst_inst", out_inst, 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_addr2", 32'(imem_addr2), 32'd62);
    rst = 1'b0;

    // stream, then stall with PC 8 at the output
    tick(); tick(); tick(); tick();
    chk("pc8_out", out_pc, 32'h8);
    chk("pc8_valid", 32'(out_valid), 32'd1);
    chk("stall_addr", 32'(imem_addr), 32'd4);
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("addr_frozen", 32'(imem_addr), 32'd4);
      chk("pc8_held", out_pc, 32'h8);
    end
    ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("stream_valid", 32'(out_valid), 32'd1);
      tick();
    end

    // redirect while output and skid are both occupied
    ready = 1'b0;
    tick(); tick(); tick();
    redirect = 1'b1; rpc = 32'h43;
    tick();
    redirect = 1'b0; ready = 1'b1;
    chk("redir_addr", 32'(imem_addr), 32'h10);
    chk("redir_v1", 32'(out_valid), 32'd0);
    tick();
    chk("redir_v2", 32'(out_valid), 32'd0);
    tick();
    chk("redir_pc40", out_pc, 32'h40);
    tick();
    chk("redir_pc44", out_pc, 32'h44);
    tick(); tick(); tick();

    // redirect in the same cycle PC 4 is popped
    redirect = 1'b1; rpc = 32'h0;
    tick();
    redirect = 1'b0;
    tick(); tick(); tick();
    chk("pop4_pc", out_pc, 32'h4);
    redirect = 1'b1; rpc = 32'h80;
    tick();
    redirect = 1'b0;
    tick(); tick();
    chk("after_pop4_pc", out_pc, 32'h80);
    tick(); tick(); tick();

    // PC wrap past 32'hFFFFFFFC
    redirect = 1'b1; rpc = 32'hFFFF_FFF6;
    tick();
    redirect = 1'b0;
    chk("wrap_redir_addr", 32'(imem_addr), 32'd61);
    for (int i = 0; i < 8; i++) tick();

    // random backpressure and redirects
    for (int i = 0; i < 600; i++) begin
      ready    = ($urandom_range(0, 9) < 7);
      redirect = ($urandom_range(0, 39) == 0);
      rpc      = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFE0 | 32'($urandom_range(0, 31))) : $urandom;
      tick();
    end
    redirect = 1'b0;

    // reset pulsed mid-stall
    ready = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midstall_rst_valid", 32'(out_valid), 32'd0);
    chk("midstall_rst_addr", 32'(imem_addr), 32'd0);
    ready = 1'b1;
    for (int i = 0; i < 8; i++) tick();

    chk("progress", 32'(pops > 100), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
